// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor: decoded instruction classes, ALU op codes
// and the control-unit state encoding.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [3:0] {
        INIT,
        FETCH,
        DECODE,
        LOAD_1,
        LOAD_2,
        STORE_1,
        STORE_2,
        ALU_EXEC,
        BR_EXEC,
        NOP_EXEC,
        HALT_ST
    } ctrl_state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition table: decides whether a branch-class instruction is taken
// given the registered flags. Non-branch classes are never taken.
module branch_cond
    import k_and_s_pkg::*;
(
    input  decoded_instruction_type i_instr,
    input  logic                    i_zero,
    input  logic                    i_neg,
    input  logic                    i_unsigned_overflow,
    input  logic                    i_signed_overflow,
    output logic                    o_taken
);

    // Unsigned overflow is reserved for a future condition and has no effect today.
    logic w_unused_uov;
    assign w_unused_uov = i_unsigned_overflow;

    always_comb begin
        o_taken = 1'b0;
        case (i_instr)
            I_BRANCH: o_taken = 1'b1;
            I_BZERO:  o_taken = i_zero;
            I_BNZERO: o_taken = !i_zero;
            I_BNEG:   o_taken = i_neg;
            I_BNNEG:  o_taken = !i_neg;
            I_BOV:    o_taken = i_signed_overflow;
            I_BNOV:   o_taken = !i_signed_overflow;
            default:  o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the K&S processor: sequences fetch/decode/execute,
// drives every data-path enable and counts retired instructions.
module control_unit
    import k_and_s_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic [CNT_W-1:0]        instr_count
);

    ctrl_state_t             r_state;
    ctrl_state_t             w_next_state;
    decoded_instruction_type r_instr;
    logic [CNT_W-1:0]        r_count;
    logic                    w_taken;

    branch_cond u_branch_cond (
        .i_instr             (r_instr),
        .i_zero              (zero_op),
        .i_neg               (neg_op),
        .i_unsigned_overflow (unsigned_overflow),
        .i_signed_overflow   (signed_overflow),
        .o_taken             (w_taken)
    );

    // The class is captured at the DECODE edge so the execute states ignore later input changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
            r_instr <= I_NOP;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == DECODE) begin
                r_instr <= decoded_instruction;
            end
            if (pc_enable) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign instr_count = r_count;

    always_comb begin
        w_next_state     = r_state;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = OP_ADD;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;

        case (r_state)
            INIT: w_next_state = FETCH;
            FETCH: begin
                addr_sel     = 1'b1;
                ir_enable    = 1'b1;
                w_next_state = DECODE;
            end
            DECODE: begin
                case (decoded_instruction)
                    I_LOAD:  w_next_state = LOAD_1;
                    I_STORE: w_next_state = STORE_1;
                    I_ADD, I_SUB, I_AND, I_OR, I_MOVE:
                        w_next_state = ALU_EXEC;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                        w_next_state = BR_EXEC;
                    I_HALT:  w_next_state = HALT_ST;
                    default: w_next_state = NOP_EXEC;
                endcase
            end
            LOAD_1:  w_next_state = LOAD_2;
            LOAD_2: begin
                write_reg_enable = 1'b1;
                pc_enable        = 1'b1;
                w_next_state     = FETCH;
            end
            STORE_1: w_next_state = STORE_2;
            STORE_2: begin
                ram_write_enable = 1'b1;
                pc_enable        = 1'b1;
                w_next_state     = FETCH;
            end
            // MOVE reuses the OR op: the data path feeds the source to both ALU inputs.
            ALU_EXEC: begin
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                pc_enable        = 1'b1;
                w_next_state     = FETCH;
                case (r_instr)
                    I_ADD: begin
                        operation        = OP_ADD;
                        flags_reg_enable = 1'b1;
                    end
                    I_SUB: begin
                        operation        = OP_SUB;
                        flags_reg_enable = 1'b1;
                    end
                    I_AND: begin
                        operation        = OP_AND;
                        flags_reg_enable = 1'b1;
                    end
                    I_OR: begin
                        operation        = OP_OR;
                        flags_reg_enable = 1'b1;
                    end
                    I_MOVE:  operation = OP_OR;
                    default: operation = OP_ADD;
                endcase
            end
            BR_EXEC: begin
                pc_enable    = 1'b1;
                branch       = w_taken;
                w_next_state = FETCH;
            end
            NOP_EXEC: begin
                pc_enable    = 1'b1;
                w_next_state = FETCH;
            end
            HALT_ST: halt = 1'b1;
            default: w_next_state = INIT;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: walks each instruction class
// cycle by cycle and compares every control output against hand-derived vectors.
module tb_control_unit;
    import k_and_s_pkg::*;

    // Output vector order: {branch, pc_enable, ir_enable, addr_sel, c_sel,
    // operation[1:0], write_reg_enable, flags_reg_enable, ram_write_enable, halt}
    localparam logic [10:0] V_ZERO    = 11'b000_0000_0000;
    localparam logic [10:0] V_FETCH   = 11'b001_1000_0000;
    localparam logic [10:0] V_LOAD2   = 11'b010_0000_1000;
    localparam logic [10:0] V_STORE2  = 11'b010_0000_0010;
    localparam logic [10:0] V_SUB     = 11'b010_0101_1100;
    localparam logic [10:0] V_MOVE    = 11'b010_0111_1000;
    localparam logic [10:0] V_BR_TAKE = 11'b110_0000_0000;
    localparam logic [10:0] V_PC_ONLY = 11'b010_0000_0000;
    localparam logic [10:0] V_HALT    = 11'b000_0000_0001;

    logic                    clk;
    logic                    rst;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;
    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable;
    logic                    flags_reg_enable;
    logic                    ram_write_enable;
    logic                    halt;
    logic [15:0]             instr_count;

    int          testsRun;
    int          testsFailed;
    logic [15:0] expCount;

    control_unit #(.CNT_W(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .ram_write_enable    (ram_write_enable),
        .halt                (halt),
        .instr_count         (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] outs();
        return {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                write_reg_enable, flags_reg_enable, ram_write_enable, halt};
    endfunction

    // Advance one cycle; optionally change the instruction input just after the edge.
    task automatic next_cycle(input logic scramble, input decoded_instruction_type junk);
        @(posedge clk);
        #1;
        if (scramble) decoded_instruction = junk;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expCount = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        decoded_instruction = I_NOP;
        zero_op = 1'b0;
        neg_op = 1'b0;
        unsigned_overflow = 1'b0;
        signed_overflow = 1'b0;
        expCount = '0;
        @(negedge clk);
        testsRun++;
        if (outs() !== V_ZERO || instr_count !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_held: outs %b count %0d, expected %b count 0", outs(), instr_count, V_ZERO);
        end
        rst = 1'b0;
        #1;
        testsRun++;
        if (outs() !== V_ZERO) begin
            testsFailed++;
            $display("[TB] FAIL reset_init: outs %b, expected %b", outs(), V_ZERO);
        end
        @(negedge clk);
        testsRun++;
        if (outs() !== V_FETCH || instr_count !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_fetch: outs %b count %0d, expected %b count 0", outs(), instr_count, V_FETCH);
        end
    endtask

    task automatic test_load();
        logic [10:0] exp [4] = '{V_FETCH, V_ZERO, V_ZERO, V_LOAD2};
        decoded_instruction = I_LOAD;
        for (int c = 0; c < 4; c++) begin
            testsRun++;
            if (outs() !== exp[c]) begin
                testsFailed++;
                $display("[TB] FAIL load_cycle%0d: outs %b, expected %b", c, outs(), exp[c]);
            end
            next_cycle(c == 1, I_HALT);
        end
        expCount = expCount + 16'd1;
        testsRun++;
        if (outs() !== V_FETCH || instr_count !== expCount) begin
            testsFailed++;
            $display("[TB] FAIL load_retire: outs %b count %0d, expected %b count %0d", outs(), instr_count, V_FETCH, expCount);
        end
    endtask

    task automatic test_store();
        logic [10:0] exp [4] = '{V_FETCH, V_ZERO, V_ZERO, V_STORE2};
        decoded_instruction = I_STORE;
        for (int c = 0; c < 4; c++) begin
            testsRun++;
            if (outs() !== exp[c]) begin
                testsFailed++;
                $display("[TB] FAIL store_cycle%0d: outs %b, expected %b", c, outs(), exp[c]);
            end
            next_cycle(c == 1, I_LOAD);
        end
        expCount = expCount + 16'd1;
        testsRun++;
        if (outs() !== V_FETCH || instr_count !== expCount) begin
            testsFailed++;
            $display("[TB] FAIL store_retire: outs %b count %0d, expected %b count %0d", outs(), instr_count, V_FETCH, expCount);
        end
    endtask

    task automatic test_alu();
        decoded_instruction_type ins [2] = '{I_SUB, I_MOVE};
        logic [10:0] expExec [2] = '{V_SUB, V_MOVE};
        for (int k = 0; k < 2; k++) begin
            decoded_instruction = ins[k];
            for (int c = 0; c < 3; c++) begin
                testsRun++;
                if (outs() !== ((c == 0) ? V_FETCH : (c == 1) ? V_ZERO : expExec[k])) begin
                    testsFailed++;
                    $display("[TB] FAIL alu%0d_cycle%0d: outs %b, expected exec %b", k, c, outs(), expExec[k]);
                end
                next_cycle(c == 1, I_ADD);
            end
            expCount = expCount + 16'd1;
            testsRun++;
            if (instr_count !== expCount) begin
                testsFailed++;
                $display("[TB] FAIL alu%0d_count: got %0d, expected %0d", k, instr_count, expCount);
            end
        end
    endtask

    task automatic test_branch();
        // Flags per entry: {zero, neg, signed_overflow, unsigned_overflow}
        decoded_instruction_type ins [7] = '{I_BZERO, I_BZERO, I_BNOV, I_BRANCH, I_BNNEG, I_BOV, I_BNZERO};
        logic [3:0] flags [7] = '{4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0010, 4'b0001};
        logic       taken [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            decoded_instruction = ins[k];
            {zero_op, neg_op, signed_overflow, unsigned_overflow} = flags[k];
            for (int c = 0; c < 3; c++) begin
                testsRun++;
                if (outs() !== ((c == 0) ? V_FETCH : (c == 1) ? V_ZERO : (taken[k] ? V_BR_TAKE : V_PC_ONLY))) begin
                    testsFailed++;
                    $display("[TB] FAIL branch%0d_cycle%0d: outs %b, expected taken=%b", k, c, outs(), taken[k]);
                end
                next_cycle(c == 1, taken[k] ? I_BNZERO : I_BRANCH);
            end
            expCount = expCount + 16'd1;
        end
        {zero_op, neg_op, signed_overflow, unsigned_overflow} = 4'b0000;
        testsRun++;
        if (instr_count !== expCount) begin
            testsFailed++;
            $display("[TB] FAIL branch_count: got %0d, expected %0d", instr_count, expCount);
        end
    endtask

    task automatic test_halt();
        do_reset();
        decoded_instruction = I_NOP;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 3; c++) begin
                testsRun++;
                if (outs() !== ((c == 0) ? V_FETCH : (c == 1) ? V_ZERO : V_PC_ONLY)) begin
                    testsFailed++;
                    $display("[TB] FAIL nop%0d_cycle%0d: outs %b", k, c, outs());
                end
                next_cycle(1'b0, I_NOP);
            end
            expCount = expCount + 16'd1;
        end
        decoded_instruction = I_HALT;
        next_cycle(1'b0, I_NOP);
        next_cycle(1'b1, I_NOP);
        for (int c = 0; c < 20; c++) begin
            testsRun++;
            if (outs() !== V_HALT || instr_count !== 16'd3) begin
                testsFailed++;
                $display("[TB] FAIL halt_cycle%0d: outs %b count %0d, expected %b count 3", c, outs(), instr_count, V_HALT);
            end
            next_cycle(1'b0, I_NOP);
        end
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        decoded_instruction = I_STORE;
        next_cycle(1'b0, I_NOP);
        next_cycle(1'b0, I_NOP);
        next_cycle(1'b0, I_NOP);
        testsRun++;
        if (outs() !== V_STORE2) begin
            testsFailed++;
            $display("[TB] FAIL midstore_store2: outs %b, expected %b", outs(), V_STORE2);
        end
        #1;
        rst = 1'b1;
        #1;
        testsRun++;
        if (outs() !== V_ZERO || instr_count !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL midstore_async: outs %b count %0d, expected %b count 0", outs(), instr_count, V_ZERO);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        testsRun++;
        if (outs() !== V_ZERO) begin
            testsFailed++;
            $display("[TB] FAIL midstore_init: outs %b, expected %b", outs(), V_ZERO);
        end
        @(negedge clk);
        testsRun++;
        if (outs() !== V_FETCH || instr_count !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL midstore_refetch: outs %b count %0d, expected %b count 0", outs(), instr_count, V_FETCH);
        end
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        test_reset();
        test_load();
        test_store();
        test_alu();
        test_branch();
        test_halt();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
